// File: rtl/fv_selftest_pkg.sv
// rtl/fv_selftest_pkg.sv - shared state encoding and constants for the fabric self-test checker
package fv_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] DEFAULT_SEED   = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS   = 16'hB400;
  localparam logic [15:0] FIRST_ERR_NONE = 16'hFFFF;

endpackage

// File: rtl/fpga_selftest_checker_if.sv
// rtl/fpga_selftest_checker_if.sv - stimulus/compare/status bundle between checker and fabric harness
interface fpga_selftest_checker_if #(
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 1,
  parameter int ERR_W   = 16
);

  logic               start;
  logic [NUM_IN-1:0]  stim_out;
  logic [NUM_OUT-1:0] dut_out;
  logic [NUM_OUT-1:0] ref_out;
  logic               busy;
  logic               done;
  logic               pass;
  logic [ERR_W-1:0]   err_count;
  logic               mismatch;
  logic [15:0]        first_err_cycle;

  // Checker side: drives stimulus and status, observes fabric responses.
  modport master (
    input  start, dut_out, ref_out,
    output stim_out, busy, done, pass, err_count, mismatch, first_err_cycle
  );

  // Harness side: pulses start, returns fabric/reference outputs.
  modport slave (
    output start, dut_out, ref_out,
    input  stim_out, busy, done, pass, err_count, mismatch, first_err_cycle
  );

endinterface

// File: rtl/fv_lfsr.sv
// rtl/fv_lfsr.sv - Galois LFSR with load and advance enables, reusable by stimulus blocks
module fv_lfsr
  import fv_selftest_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state,
  output logic [LFSR_W-1:0] o_next
);

  // An all-zero state would lock the LFSR, so a zero seed loads as 1.
  localparam logic [LFSR_W-1:0] LOAD_VAL = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  assign o_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign o_state = r_lfsr;

  // Load has priority over advance so a restart always begins from the seed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= LOAD_VAL;
    end else if (i_en) begin
      r_lfsr <= o_next;
    end
  end

endmodule

// File: rtl/fpga_selftest_checker.sv
// rtl/fpga_selftest_checker.sv - random-stimulus fabric vs reference compare with edge-counted error scoreboard
module fpga_selftest_checker
  import fv_selftest_pkg::*;
#(
  parameter int                NUM_IN        = 2,
  parameter int                NUM_OUT       = 1,
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] SEED          = LFSR_W'(DEFAULT_SEED),
  parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(DEFAULT_TAPS),
  parameter int                RUN_CYCLES    = 400,
  parameter int                WARMUP_CYCLES = 1,
  parameter int                ERR_W         = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  fpga_selftest_checker_if.master bus
);

  localparam int               CYC_W    = $clog2(RUN_CYCLES) + 1;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(RUN_CYCLES - 1);
  localparam logic [CYC_W-1:0] WARM_CYC = CYC_W'(WARMUP_CYCLES);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]         r_state;
  logic [CYC_W-1:0]   r_cyc;
  logic [NUM_IN-1:0]  r_stim;
  logic [ERR_W-1:0]   r_err;
  logic               r_mm;
  logic [15:0]        r_first;

  logic               w_start;
  logic               w_run;
  logic [NUM_OUT-1:0] w_diff;
  logic               w_mm_now;
  logic               w_count;
  logic [LFSR_W-1:0]  w_lfsr;
  logic [LFSR_W-1:0]  w_lfsr_next;
  logic               w_unused_lfsr;

  // start only matters outside RUN; a pulse mid-run is dropped.
  assign w_run    = (r_state == S_RUN);
  assign w_start  = bus.start && !w_run;
  assign w_diff   = bus.dut_out ^ bus.ref_out;
  // Compare against the stimulus currently held; warm-up cycles are masked.
  assign w_mm_now = (r_cyc >= WARM_CYC) && (|w_diff);
  // One event per contiguous burst of mismatching cycles.
  assign w_count  = w_mm_now && !r_mm;

  // Only the low stimulus bits of the next state are consumed.
  assign w_unused_lfsr = ^{w_lfsr, w_lfsr_next};

  fv_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED),
    .TAPS   (TAPS)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_start),
    .i_en    (w_run),
    .o_state (w_lfsr),
    .o_next  (w_lfsr_next)
  );

  // Run sequencing, stimulus register and mismatch scoreboard.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_stim  <= '0;
      r_err   <= '0;
      r_mm    <= 1'b0;
      r_first <= FIRST_ERR_NONE;
    end else begin
      case (r_state)
        S_RUN: begin
          r_stim <= w_lfsr_next[NUM_IN-1:0];
          r_mm   <= w_mm_now;
          if (w_count) begin
            if (!(&r_err)) begin
              r_err <= r_err + 1'b1;
            end
            // err_count never returns to zero within a run, so zero marks the first event.
            if (r_err == '0) begin
              r_first <= 16'(r_cyc);
            end
          end
          if (r_cyc == LAST_CYC) begin
            r_state <= S_DONE;
            r_mm    <= 1'b0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_cyc   <= '0;
            r_stim  <= SEED[NUM_IN-1:0];
            r_err   <= '0;
            r_mm    <= 1'b0;
            r_first <= FIRST_ERR_NONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stim_out        = r_stim;
  assign bus.busy            = w_run;
  assign bus.done            = (r_state == S_DONE);
  assign bus.pass            = (r_state == S_DONE) && (r_err == '0);
  assign bus.err_count       = r_err;
  assign bus.mismatch        = r_mm;
  assign bus.first_err_cycle = r_first;

endmodule

// File: tb/tb_fpga_selftest_checker.sv
// tb/tb_fpga_selftest_checker.sv - directed and randomized self-checking bench for fpga_selftest_checker
module tb_fpga_selftest_checker;

  localparam int          RUN_N  = 400;
  localparam int          WARM   = 1;
  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam logic [15:0] TAPS_V = 16'hB400;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [0:0] dut_v = 1'b0;
  logic [0:0] ref_v = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_stim [RUN_N];
  logic       inj      [RUN_N];

  always #5 clk = ~clk;

  fpga_selftest_checker_if #(.NUM_IN(2), .NUM_OUT(1), .ERR_W(16)) bus_m ();
  fpga_selftest_checker_if #(.NUM_IN(2), .NUM_OUT(1), .ERR_W(2))  bus_s ();

  assign bus_m.start   = start;
  assign bus_m.dut_out = dut_v;
  assign bus_m.ref_out = ref_v;
  assign bus_s.start   = start;
  assign bus_s.dut_out = dut_v;
  assign bus_s.ref_out = ref_v;

  fpga_selftest_checker #(
    .NUM_IN(2), .NUM_OUT(1), .LFSR_W(16), .SEED(SEED_V), .TAPS(TAPS_V),
    .RUN_CYCLES(RUN_N), .WARMUP_CYCLES(WARM), .ERR_W(16)
  ) u_main (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus_m.master)
  );

  fpga_selftest_checker #(
    .NUM_IN(2), .NUM_OUT(1), .LFSR_W(16), .SEED(SEED_V), .TAPS(TAPS_V),
    .RUN_CYCLES(RUN_N), .WARMUP_CYCLES(WARM), .ERR_W(2)
  ) u_sat (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus_s.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  32'(bus_m.busy),            32'd0);
    check({tag, "_done"},  32'(bus_m.done),            32'd0);
    check({tag, "_pass"},  32'(bus_m.pass),            32'd0);
    check({tag, "_err"},   32'(bus_m.err_count),       32'd0);
    check({tag, "_mm"},    32'(bus_m.mismatch),        32'd0);
    check({tag, "_first"}, 32'(bus_m.first_err_cycle), 32'hFFFF);
    check({tag, "_stim"},  32'(bus_m.stim_out),        32'd0);
    check({tag, "_s_err"}, 32'(bus_s.err_count),       32'd0);
    check({tag, "_s_busy"}, 32'(bus_s.busy),           32'd0);
  endtask

  task automatic build_pattern(input int mode);
    bit lvl;
    lvl = 1'b0;
    for (int c = 0; c < RUN_N; c++) begin
      case (mode)
        0:       inj[c] = 1'b0;
        1:       inj[c] = 1'b1;
        2:       inj[c] = (c >= 2) && (c % 2 == 0);
        3:       inj[c] = ($urandom_range(0, 3) == 0);
        4:       inj[c] = (c == 0);
        default: begin
          if ($urandom_range(0, 15) == 0) lvl = !lvl;
          inj[c] = lvl;
        end
      endcase
    end
  endtask

  // One run: pulse start, feed responses per cycle, compare to the model at the end.
  task automatic do_run(input int mode, input bit noise, input int reset_at, input bit chk4,
                        input string tag);
    logic       m [RUN_N];
    logic [1:0] k4 [4];
    bit         prev;
    int         cnt, first, busy_n, done_bad, stim_bad, mm_bad;
    k4[0] = 2'b01; k4[1] = 2'b00; k4[2] = 2'b00; k4[3] = 2'b00;
    build_pattern(mode);
    cnt = 0; first = 32'hFFFF; prev = 1'b0;
    busy_n = 0; done_bad = 0; stim_bad = 0; mm_bad = 0;
    for (int c = 0; c < RUN_N; c++) begin
      m[c] = inj[c] && (c >= WARM);
      if (m[c] && !prev) cnt++;
      if (m[c] && first == 32'hFFFF) first = c;
      prev = m[c];
    end

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < RUN_N; c++) begin
      start = 1'b0;
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state({tag, "_midreset"});
        return;
      end
      if (bus_m.busy === 1'b1) busy_n++;
      if (bus_m.done !== 1'b0) done_bad++;
      if (bus_m.stim_out !== exp_stim[c]) stim_bad++;
      if (bus_s.stim_out !== exp_stim[c]) stim_bad++;
      if (c > 0 && bus_m.mismatch !== m[c-1]) mm_bad++;
      if (chk4 && c < 4) check($sformatf("%s_stim_c%0d", tag, c), 32'(bus_m.stim_out), 32'(k4[c]));
      ref_v = ^bus_m.stim_out;
      dut_v = ref_v ^ inj[c];
      if (noise && c < RUN_N - 1 && $urandom_range(0, 7) == 0) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;

    check({tag, "_busy_cycles"}, busy_n,   RUN_N);
    check({tag, "_done_early"},  done_bad, 0);
    check({tag, "_stim_seq"},    stim_bad, 0);
    check({tag, "_mm_seq"},      mm_bad,   0);
    check({tag, "_busy_end"},    32'(bus_m.busy),            32'd0);
    check({tag, "_done"},        32'(bus_m.done),            32'd1);
    check({tag, "_mm_end"},      32'(bus_m.mismatch),        32'd0);
    check({tag, "_err"},         32'(bus_m.err_count),       (cnt > 65535) ? 65535 : cnt);
    check({tag, "_first"},       32'(bus_m.first_err_cycle), first);
    check({tag, "_pass"},        32'(bus_m.pass),            (cnt == 0) ? 1 : 0);
    check({tag, "_s_err"},       32'(bus_s.err_count),       (cnt > 3) ? 3 : cnt);
    check({tag, "_s_pass"},      32'(bus_s.pass),            (cnt == 0) ? 1 : 0);
    check({tag, "_s_first"},     32'(bus_s.first_err_cycle), first);
  endtask

  initial begin
    logic [15:0] st;
    st = SEED_V;
    for (int c = 0; c < RUN_N; c++) begin
      exp_stim[c] = st[1:0];
      st = (st >> 1) ^ (st[0] ? TAPS_V : 16'h0000);
    end

    repeat (3) @(negedge clk);
    check_reset_state("por");

    start = 1'b1;
    @(negedge clk);
    check("rst_and_start_busy", 32'(bus_m.busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus_m.busy), 32'd0);
    check("idle_done", 32'(bus_m.done), 32'd0);

    do_run(0, 1'b1, -1, 1'b1, "clean");
    do_run(1, 1'b0, -1, 1'b0, "allmm");
    do_run(2, 1'b1, -1, 1'b0, "alt");
    do_run(4, 1'b0, -1, 1'b0, "warm_only");
    do_run(1, 1'b1, 150, 1'b0, "abort");
    do_run(3, 1'b1, -1, 1'b1, "rand_a");
    do_run(5, 1'b0, -1, 1'b0, "burst");
    do_run(3, 1'b0, -1, 1'b0, "rand_b");

    repeat (3) @(negedge clk);
    check("done_hold", 32'(bus_m.done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
